// File: rtl/pkt_wr_ctrl.sv
// pkt_wr_ctrl: Avalon-MM burst write master draining a show-ahead FIFO into
// the byte window [pkt_begin, pkt_end). A burst is launched only once the FIFO
// already holds every word of it, so the slave never sees a mid-burst bubble.
module pkt_wr_ctrl #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned USEDW_W   = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_ctrl,
  input  logic [31:0]        pkt_begin,
  input  logic [31:0]        pkt_end,
  input  logic [31:0]        fifo_out,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               fifo_rdreq,
  output logic               wr_ctrl_rdy,
  output logic               wr_ctrl_done,
  output logic [31:0]        bytes_written,
  output logic [31:0]        address,
  output logic               write,
  output logic [31:0]        writedata,
  output logic [15:0]        burstcount,
  input  logic               waitrequest
);

  typedef enum logic [1:0] {StIdle, StArm, StBurst, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [29:0] remaining_q, remaining_d;
  logic [31:0] bytes_q, bytes_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic [15:0] beat_q, beat_d;

  logic [15:0] len;
  logic        accept;
  logic        last_beat;
  logic [29:0] rem_after;
  logic [29:0] win_words;

  // Byte-lane bits of the window bounds carry no information.
  logic unused_lsbs;
  assign unused_lsbs = ^{pkt_begin[1:0], pkt_end[1:0]};

  // Datapath helpers shared by the next-state logic and the outputs.
  always_comb begin
    len       = (remaining_q < 30'(MAX_BURST)) ? 16'(remaining_q) : 16'(MAX_BURST);
    accept    = (state_q == StBurst) && !waitrequest;
    last_beat = accept && (beat_q == (bcnt_q - 16'd1));
    rem_after = remaining_q - 30'(bcnt_q);
    win_words = pkt_end[31:2] - pkt_begin[31:2];
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    bytes_d     = bytes_q;
    addr_d      = addr_q;
    bcnt_d      = bcnt_q;
    beat_d      = beat_q;
    unique case (state_q)
      StIdle: begin
        if (wr_ctrl) begin
          cur_addr_d = {pkt_begin[31:2], 2'b00};
          bytes_d    = 32'd0;
          // Compare word addresses so an empty/inverted window never arms a 0-beat burst.
          if (pkt_end[31:2] <= pkt_begin[31:2]) begin
            remaining_d = 30'd0;
            state_d     = StDone;
          end else begin
            remaining_d = win_words;
            state_d     = StArm;
          end
        end
      end
      StArm: begin
        if (!wr_ctrl) begin
          state_d = StIdle;
        end else if (32'(fifo_usedw) >= 32'(len)) begin
          addr_d  = cur_addr_q;
          bcnt_d  = len;
          beat_d  = 16'd0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (accept) begin
          beat_d  = beat_q + 16'd1;
          bytes_d = bytes_q + 32'd4;
        end
        if (last_beat) begin
          cur_addr_d  = cur_addr_q + {14'd0, bcnt_q, 2'b00};
          remaining_d = rem_after;
          if (rem_after == 30'd0) begin
            state_d = StDone;
          end else if (!wr_ctrl) begin
            state_d = StIdle;
          end else begin
            state_d = StArm;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_addr_q  <= 32'd0;
      remaining_q <= 30'd0;
      bytes_q     <= 32'd0;
      addr_q      <= 32'd0;
      bcnt_q      <= 16'd0;
      beat_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      bytes_q     <= bytes_d;
      addr_q      <= addr_d;
      bcnt_q      <= bcnt_d;
      beat_q      <= beat_d;
    end
  end

  // Outputs decoded from state; the FIFO pop tracks the accepted beat combinationally.
  always_comb begin
    write         = (state_q == StBurst);
    fifo_rdreq    = accept;
    writedata     = fifo_out;
    wr_ctrl_rdy   = (state_q == StIdle);
    wr_ctrl_done  = (state_q == StDone);
    bytes_written = bytes_q;
    address       = addr_q;
    burstcount    = bcnt_q;
  end

endmodule
